ro_freq_meter_wb: RTL and testbench

//  Wishbone-readable frequency meter for the on-chip ring-oscillator array.
//  It selects one oscillator output and counts its rising edges over a

---
 rtl/ro_freq_meter_wb.sv | 230 +++++++++++++++++++++++
 tb/tb_ro_freq_meter_wb.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_meter_wb.sv
// ro_freq_meter_wb
//   Wishbone-readable frequency meter for the ring-oscillator array. One
//   oscillator is selected and its rising edges are counted over a
//   programmable window of wb_clk_i cycles. Firmware derives the frequency
//   as f = COUNT * f_clk / WINDOW.
//
// Ports
//   wb_clk_i, wb_rst_i    clock, asynchronous active-high reset
//   wbs_stb_i/cyc_i/we_i  Wishbone slave request
//   wbs_sel_i, wbs_dat_i  byte enables and write data
//   wbs_adr_i             byte address; BASE_ADDR..BASE_ADDR+0xF is decoded
//   wbs_ack_o, wbs_dat_o  one-cycle acknowledge and read data (0 when idle)
//   ro_in                 raw oscillator outputs, asynchronous to wb_clk_i
//   busy_o                measurement in progress
//   irq_o                 level interrupt, STATUS.done & CTRL.irq_en
//
// Register map (adr[3:2])
//   0x0 CTRL   [3:0] sel, [8] start (pulse), [9] abort (pulse), [16] irq_en
//   0x4 WINDOW [WIN_W-1:0] window length in cycles
//   0x8 COUNT  [CNT_W-1:0] last result (read only)
//   0xC STATUS [0] busy, [1] done (W1C), [2] ovf (W1C)

module ro_freq_meter_wb #(
    parameter int          N_RO      = 10,
    parameter int          CNT_W     = 24,
    parameter int          WIN_W     = 24,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [N_RO-1:0] ro_in,
    output logic            busy_o,
    output logic            irq_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, COUNT = 2'd2} state_t;

    state_t state, next_state;

    logic             addr_hit, req, wr;
    logic [1:0]       reg_idx;
    logic             wr_ctrl, wr_window, wr_status;
    logic [31:0]      be_mask, window_ext, window_merged, rdata;
    logic             start_req, abort_req, clr_done, clr_ovf;

    logic [3:0]       ctrl_sel;
    logic             irq_en;
    logic [WIN_W-1:0] window;
    logic [CNT_W-1:0] count_reg;
    logic             done, ovf;

    logic [3:0]       meas_sel;
    logic [WIN_W-1:0] meas_win, win_cnt;
    logic [CNT_W-1:0] edge_cnt;

    logic [N_RO-1:0]  sync1, sync2;
    logic [15:0]      sync_pad;
    logic             ro_sel, ro_dly, edge_pulse;

    logic             launch, arm_load, counting, finish, finish_zero, busy;
    logic             unused_bits;

    // Bus decode. req excludes the ack cycle so every access is acked once.
    assign addr_hit  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & addr_hit;
    assign wr        = req & wbs_we_i;
    assign reg_idx   = wbs_adr_i[3:2];
    assign wr_ctrl   = wr & (reg_idx == 2'd0);
    assign wr_window = wr & (reg_idx == 2'd1);
    assign wr_status = wr & (reg_idx == 2'd3);

    assign be_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign window_ext    = 32'(window);
    assign window_merged = (window_ext & ~be_mask) | (wbs_dat_i & be_mask);

    assign start_req = wr_ctrl & wbs_sel_i[1] & wbs_dat_i[8];
    assign abort_req = wr_ctrl & wbs_sel_i[1] & wbs_dat_i[9];
    assign clr_done  = wr_status & wbs_sel_i[0] & wbs_dat_i[1];
    assign clr_ovf   = wr_status & wbs_sel_i[0] & wbs_dat_i[2];

    // Each oscillator is synchronised before the mux so that changing the
    // selection can never produce a runt pulse; the third flop after the
    // mux provides the rising-edge detector.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1  <= '0;
            sync2  <= '0;
            ro_dly <= 1'b0;
        end else begin
            sync1  <= ro_in;
            sync2  <= sync1;
            ro_dly <= ro_sel;
        end
    end

    // Zero padding to 16 entries makes any sel >= N_RO pick a constant 0.
    assign sync_pad   = 16'(sync2);
    assign ro_sel     = sync_pad[meas_sel];
    assign edge_pulse = ro_sel & ~ro_dly;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_req && !abort_req) next_state = ARM;
            ARM:     if (abort_req || meas_win == '0) next_state = IDLE;
                     else next_state = COUNT;
            COUNT:   if (abort_req || win_cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Abort suppresses every datapath action so COUNT and done keep their
    // previous values.
    always_comb begin
        launch      = 1'b0;
        arm_load    = 1'b0;
        counting    = 1'b0;
        finish      = 1'b0;
        finish_zero = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: launch = start_req & ~abort_req;
            ARM: begin
                if (!abort_req) begin
                    arm_load = 1'b1;
                    if (meas_win == '0) begin
                        finish_zero = 1'b1;
                        finish      = 1'b1;
                    end
                end
            end
            COUNT: begin
                if (!abort_req) begin
                    if (win_cnt != '0) counting = 1'b1;
                    else               finish   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // The measurement works on private copies of sel and WINDOW, so register
    // writes while busy never disturb a running window. The copy of sel takes
    // the value written alongside start when that byte is enabled.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl_sel  <= '0;
            irq_en    <= 1'b0;
            window    <= '0;
            count_reg <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            meas_sel  <= '0;
            meas_win  <= '0;
            win_cnt   <= '0;
            edge_cnt  <= '0;
        end else begin
            if (wr_ctrl) begin
                if (wbs_sel_i[0]) ctrl_sel <= wbs_dat_i[3:0];
                if (wbs_sel_i[2]) irq_en   <= wbs_dat_i[16];
            end
            if (wr_window) window <= window_merged[WIN_W-1:0];

            if (launch) begin
                meas_sel <= wbs_sel_i[0] ? wbs_dat_i[3:0] : ctrl_sel;
                meas_win <= window;
            end

            if (arm_load) begin
                edge_cnt <= '0;
                win_cnt  <= meas_win;
            end else if (counting) begin
                win_cnt <= win_cnt - WIN_W'(1);
                if (edge_pulse && !(&edge_cnt)) edge_cnt <= edge_cnt + CNT_W'(1);
            end

            if (finish) count_reg <= finish_zero ? '0 : edge_cnt;

            // Hardware set has priority over a simultaneous W1C.
            if (finish)        done <= 1'b1;
            else if (clr_done) done <= 1'b0;

            if (counting && edge_pulse && (&edge_cnt)) ovf <= 1'b1;
            else if (arm_load || clr_ovf)              ovf <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            2'd0: begin
                rdata[3:0] = ctrl_sel;
                rdata[16]  = irq_en;
            end
            2'd1:    rdata      = window_ext;
            2'd2:    rdata      = 32'(count_reg);
            default: rdata[2:0] = {ovf, done, busy};
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
        end
    end

    assign busy_o = busy;
    assign irq_o  = done & irq_en;

    assign unused_bits = ^{wbs_adr_i[1:0], window_merged};

endmodule

// File: tb/tb_ro_freq_meter_wb.sv
// tb_ro_freq_meter_wb
//   Directed bench for ro_freq_meter_wb. Two instances share one Wishbone
//   bus: unit A (defaults, base 0x3000_0000) and unit B (CNT_W=8, base
//   0x3000_0010) for saturation. Oscillator stand-ins are derived from a
//   free-running tick: ro_in[3]=clk/8, ro_in[5]=clk/4, ro_in[2]=clk/16,
//   ro_in[6]=clk/32.

module tb_ro_freq_meter_wb;

    localparam logic [31:0] BASE_A = 32'h3000_0000;
    localparam logic [31:0] BASE_B = 32'h3000_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic [9:0]  ro_in;
    logic        ack_a, ack_b, busy_a, busy_b, irq_a, irq_b;
    logic [31:0] dato_a, dato_b;

    int n_vec = 0;
    int n_err = 0;
    int tick  = 0;

    always #5 clk = ~clk;

    ro_freq_meter_wb #(.N_RO(10), .CNT_W(24), .WIN_W(24), .BASE_ADDR(BASE_A)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(ack_a), .wbs_dat_o(dato_a), .ro_in(ro_in),
        .busy_o(busy_a), .irq_o(irq_a)
    );

    ro_freq_meter_wb #(.N_RO(10), .CNT_W(8), .WIN_W(24), .BASE_ADDR(BASE_B)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(ack_b), .wbs_dat_o(dato_b), .ro_in(ro_in),
        .busy_o(busy_b), .irq_o(irq_b)
    );

    initial begin
        ro_in = '0;
        forever begin
            @(negedge clk);
            tick = tick + 1;
            ro_in[2] = tick[3];
            ro_in[3] = tick[2];
            ro_in[5] = tick[1];
            ro_in[6] = tick[4];
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Only the addressed unit acks, and an idle unit drives 0 on dat_o.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output logic got);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        got = 1'b0;
        r   = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack_a | ack_b) begin
                got = 1'b1;
                r   = dato_a | dato_b;
                break;
            end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        logic        got;
        wb_xfer(1'b1, a, d, s, r, got);
        n_vec++;
        if (!got) begin
            n_err++;
            $display("[TB] FAIL write_ack adr=%h: ack=0 required ack=1", a);
        end
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
        logic got;
        wb_xfer(1'b0, a, 32'h0, 4'hF, r, got);
        n_vec++;
        if (!got) begin
            n_err++;
            $display("[TB] FAIL read_ack adr=%h: ack=0 required ack=1", a);
        end
    endtask

    task automatic wait_done(input logic [31:0] base, input int max_reads, output logic ok);
        logic [31:0] r;
        ok = 1'b0;
        for (int i = 0; i < max_reads && !ok; i++) begin
            wb_read(base + 32'hC, r);
            if (r[1]) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] r;
        n_vec++;
        if ({busy_a, irq_a, ack_a, busy_b, irq_b, ack_b} !== 6'b0 || dato_a !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: busy/irq/ack=%b dat=%h required 0",
                     {busy_a, irq_a, ack_a, busy_b, irq_b, ack_b}, dato_a);
        end
        for (int i = 0; i < 4; i++) begin
            wb_read(BASE_A + 32'(4 * i), r);
            n_vec++;
            if (r !== 32'h0) begin
                n_err++;
                $display("[TB] FAIL reset_reg%0d: got %h required 00000000", i, r);
            end
        end
        // Hold stb through two edges: ack must rise once, then drop.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE_A + 32'h8; sel = 4'hF;
        @(posedge clk); #1;
        n_vec++;
        if (ack_a !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL ack_rise: got %b required 1", ack_a);
        end
        @(posedge clk); #1;
        n_vec++;
        if (ack_a !== 1'b0 || dato_a !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL ack_one_cycle: ack=%b dat=%h required ack=0 dat=0", ack_a, dato_a);
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_decode;
        logic [31:0] r;
        logic        got;
        wb_xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, r, got);
        n_vec++;
        if (got !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL out_of_range: ack=%b required 0", got);
        end
        wb_write(BASE_A + 32'h4, 32'h1234_5678, 4'b0011);
        wb_read(BASE_A + 32'h4, r);
        n_vec++;
        if (r !== 32'h0000_5678) begin
            n_err++;
            $display("[TB] FAIL byte_enable: got %h required 00005678", r);
        end
        wb_write(BASE_A + 32'h4, 32'hAB12_3456, 4'hF);
        wb_read(BASE_A + 32'h4, r);
        n_vec++;
        if (r !== 32'h0012_3456) begin
            n_err++;
            $display("[TB] FAIL window_width: got %h required 00123456", r);
        end
        wb_write(BASE_A, 32'hFFFF_FCFF, 4'hF);
        wb_read(BASE_A, r);
        n_vec++;
        if (r !== 32'h0001_000F) begin
            n_err++;
            $display("[TB] FAIL ctrl_undef_bits: got %h required 0001000F", r);
        end
        wb_write(BASE_A, 32'h0, 4'hF);
    endtask

    task automatic test_basic;
        logic [31:0] r;
        logic        ok;
        wb_write(BASE_A + 32'h4, 32'd1000, 4'hF);
        wb_write(BASE_A, 32'h0000_0103, 4'hF);
        wb_read(BASE_A + 32'hC, r);
        n_vec++;
        if (r !== 32'h1 || busy_a !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL basic_busy: status=%h busy_o=%b required 1/1", r, busy_a);
        end
        wait_done(BASE_A, 1000, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("[TB] FAIL basic_done: done=0 required 1");
        end
        wb_read(BASE_A + 32'h8, r);
        n_vec++;
        if (r < 32'd124 || r > 32'd126) begin
            n_err++;
            $display("[TB] FAIL basic_count: got %0d required 125+/-1", r);
        end
        wb_read(BASE_A + 32'hC, r);
        n_vec++;
        if (r !== 32'h2 || irq_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL basic_status: status=%h irq=%b required 2/0", r, irq_a);
        end
    endtask

    task automatic test_abort;
        logic [31:0] r;
        wb_write(BASE_A + 32'hC, 32'h6, 4'hF);
        wb_write(BASE_A, 32'h0000_0103, 4'hF);
        repeat (50) @(posedge clk);
        wb_write(BASE_A, 32'h0000_0203, 4'hF);
        n_vec++;
        if (busy_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_busy: busy_o=%b required 0", busy_a);
        end
        repeat (1100) @(posedge clk);
        wb_read(BASE_A + 32'hC, r);
        n_vec++;
        if (r !== 32'h0 || irq_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_status: status=%h irq=%b required 0/0", r, irq_a);
        end
        wb_read(BASE_A + 32'h8, r);
        n_vec++;
        if (r < 32'd124 || r > 32'd126) begin
            n_err++;
            $display("[TB] FAIL abort_count_kept: got %0d required 125+/-1", r);
        end
        wb_write(BASE_A, 32'h0000_0303, 4'hF);
        wb_read(BASE_A + 32'hC, r);
        n_vec++;
        if (r !== 32'h0 || busy_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL start_abort_same: status=%h busy=%b required 0/0", r, busy_a);
        end
    endtask

    task automatic test_zero_window;
        logic [31:0] r;
        wb_write(BASE_A + 32'h4, 32'h0, 4'hF);
        wb_write(BASE_A, 32'h0000_0103, 4'hF);
        wb_read(BASE_A + 32'hC, r);
        n_vec++;
        if (r !== 32'h2) begin
            n_err++;
            $display("[TB] FAIL zero_window_status: got %h required 00000002", r);
        end
        wb_read(BASE_A + 32'h8, r);
        n_vec++;
        if (r !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL zero_window_count: got %0d required 0", r);
        end
    endtask

    task automatic test_irq;
        logic [31:0] r;
        wb_write(BASE_A + 32'hC, 32'h6, 4'hF);
        wb_write(BASE_A + 32'h4, 32'd200, 4'hF);
        wb_write(BASE_A, 32'h0001_0103, 4'hF);
        repeat (100) @(posedge clk);
        wb_write(BASE_A, 32'h0001_0103, 4'hF);
        repeat (120) @(posedge clk);
        wb_read(BASE_A + 32'hC, r);
        n_vec++;
        if (r !== 32'h2 || irq_a !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL irq_no_restart: status=%h irq=%b required 2/1", r, irq_a);
        end
        wb_read(BASE_A + 32'h8, r);
        n_vec++;
        if (r < 32'd24 || r > 32'd26) begin
            n_err++;
            $display("[TB] FAIL irq_count: got %0d required 25+/-1", r);
        end
        repeat (20) @(posedge clk);
        #1;
        n_vec++;
        if (irq_a !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL irq_level: got %b required 1", irq_a);
        end
        wb_write(BASE_A + 32'hC, 32'h2, 4'hF);
        n_vec++;
        if (irq_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL irq_clear: got %b required 0", irq_a);
        end
    endtask

    task automatic test_sel_range;
        logic [31:0] r;
        logic        ok;
        wb_write(BASE_A, 32'h0, 4'hF);
        wb_write(BASE_A + 32'h4, 32'd100, 4'hF);
        wb_write(BASE_A, 32'h0000_010F, 4'hF);
        wb_read(BASE_A, r);
        n_vec++;
        if (r !== 32'h0000_000F) begin
            n_err++;
            $display("[TB] FAIL ctrl_readback: got %h required 0000000F", r);
        end
        wait_done(BASE_A, 200, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("[TB] FAIL sel15_done: done=0 required 1");
        end
        wb_read(BASE_A + 32'h8, r);
        n_vec++;
        if (r !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL sel15_count: got %0d required 0", r);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] r;
        logic        ok;
        wb_write(BASE_B + 32'h4, 32'd1100, 4'hF);
        wb_write(BASE_B, 32'h0000_0105, 4'hF);
        wait_done(BASE_B, 1500, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("[TB] FAIL ovf_done: done=0 required 1");
        end
        wb_read(BASE_B + 32'h8, r);
        n_vec++;
        if (r !== 32'd255) begin
            n_err++;
            $display("[TB] FAIL ovf_count: got %0d required 255", r);
        end
        wb_read(BASE_B + 32'hC, r);
        n_vec++;
        if (r !== 32'h6) begin
            n_err++;
            $display("[TB] FAIL ovf_status: got %h required 00000006", r);
        end
        wb_write(BASE_B + 32'hC, 32'h6, 4'hF);
        wb_read(BASE_B + 32'hC, r);
        n_vec++;
        if (r !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL ovf_w1c: got %h required 00000000", r);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        wb_write(BASE_A + 32'h4, 32'd1000, 4'hF);
        wb_write(BASE_A, 32'h0000_0103, 4'hF);
        repeat (20) @(posedge clk);
        #1;
        n_vec++;
        if (busy_a !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL mid_busy: got %b required 1", busy_a);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (busy_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL mid_reset_busy: got %b required 0", busy_a);
        end
        @(negedge clk);
        rst = 1'b0;
        wb_read(BASE_A + 32'hC, r);
        n_vec++;
        if (r !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL mid_reset_status: got %h required 00000000", r);
        end
        wb_read(BASE_A + 32'h4, r);
        n_vec++;
        if (r !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL mid_reset_window: got %h required 00000000", r);
        end
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        sel = 4'h0; dat_i = '0; adr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset;
        test_decode;
        test_basic;
        test_abort;
        test_zero_window;
        test_irq;
        test_sel_range;
        test_overflow;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
